line_window_gen: RTL and testbench
==================================

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 Parameter PIX_W, default 8: bits per pixel.
REQ-002 Parameter IMG_W, default 512: pixels per image line; legal range 8..4096.
REQ-003 Parameter KSIZE, default 3: window height and width; legal values 3, 5, 7.
REQ-004 Parameter NUM_LB, default KSIZE+1: number of line buffers; fixed at KSIZE+1, not overridable.
REQ-005 i_clk  in  1: the single clock; all logic rising-edge.
REQ-006 i_rst  in  1: reset, synchronous and active-high.
REQ-007 i_pixel_data  in  PIX_W: raster-order input pixel.
REQ-008 i_data_valid  in  1: input pixel valid; a pixel is accepted when i_data_valid and o_in_ready are both high.
REQ-009 o_in_ready  out  1: block can accept an input pixel.
REQ-010 o_pixel_data  out  KSIZE*KSIZE*PIX_W: window; element (r,c) at bits [(r*KSIZE+c)*PIX_W +: PIX_W], r=0 oldest row, c=0 leftmost column.
REQ-011 o_pixel_data_valid  out  1: window valid.
REQ-012 i_out_ready  in  1: downstream accepts the window when valid and ready are both high.
REQ-013 o_intr  out  1: one-cycle pulse when the last window of an output row is accepted.

Function
REQ-014 Accepted pixels SHALL be written round-robin: IMG_W pixels into line buffer wr_sel, then wr_sel increments modulo NUM_LB.
REQ-015 lines_stored (0..NUM_LB) SHALL increment on write-line completion, decrement on read-row completion, and stay unchanged when both occur in the same cycle.
REQ-016 o_in_ready SHALL equal (lines_stored < NUM_LB), combinationally from registered state.
REQ-017 FSM states: IDLE, RD_ROW.
REQ-018 IDLE -> RD_ROW when lines_stored >= KSIZE; rd_col is cleared on entry.
REQ-019 In RD_ROW, the block SHALL emit IMG_W-KSIZE+1 windows; window at rd_col covers columns rd_col..rd_col+KSIZE-1 of the KSIZE lines starting at rd_sel.
REQ-020 rd_col SHALL advance only on an accepted window.
REQ-021 On acceptance of window rd_col = IMG_W-KSIZE: o_intr pulses next cycle, rd_sel increments modulo NUM_LB, read-row completion is signalled, FSM returns to IDLE.
REQ-022 Output SHALL be registered; first o_pixel_data_valid no earlier than 1 and no later than 2 cycles after entry to RD_ROW.
REQ-023 Back-to-back accepted windows SHALL sustain one window per cycle when i_out_ready is held high.
REQ-024 While o_pixel_data_valid=1 and i_out_ready=0, o_pixel_data SHALL remain stable.
REQ-025 Writes into the line being filled SHALL proceed concurrently with reads of the other KSIZE lines; the write buffer is never a read source.
REQ-026 Index arithmetic SHALL use widths of $clog2(IMG_W) and $clog2(NUM_LB), with explicit modulo wrap when NUM_LB is not a power of two.

Reset
REQ-027 On i_rst: o_pixel_data_valid=0, o_intr=0, o_pixel_data=0, FSM=IDLE, lines_stored=0, wr_sel=rd_sel=0, column counters=0; o_in_ready=1 the cycle after reset.
REQ-028 Reset mid-row SHALL discard all buffered lines and the partial window; line-buffer RAM contents need not be cleared.

Structure
REQ-029 Package lwg_pkg SHALL hold the FSM state enum and a function giving window count (IMG_W-KSIZE+1).
REQ-030 One sub-module, lwg_line_buffer (IMG_W x PIX_W, one write port, registered KSIZE-pixel read at a column index), SHALL be instantiated NUM_LB times via generate.

Verification (IMG_W=8, KSIZE=3, PIX_W=8 unless stated)
REQ-031 Stream 3 lines, pixel = line*16+col, i_out_ready=1 -> 6 windows; first window = {0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22} in element order (0,0)..(2,2); o_intr after the 6th.
REQ-032 Same stream, i_out_ready toggling 1,0,0,1 -> identical window sequence; data stable during stalls; no duplicates or drops.
REQ-033 Stream 6 lines with i_out_ready=0 -> o_in_ready falls after 4 lines are stored; pixel 32 is held off until row 0 is read.
REQ-034 Continuous input and i_out_ready=1 over 10 lines -> 8 o_intr pulses; lines_stored never exceeds 4; row k window 0 element (0,0)=k*16.
REQ-035 Assert i_rst after window 3 of row 0, then restream -> all outputs 0; the first window after reset is again 0x00..0x22.
REQ-036 KSIZE=5, IMG_W=16 -> 12 windows per row; row 0 window 11 element (4,4)=0x4F.

Source files
------------

// File: rtl/lwg_pkg.sv
// Shared FSM state type and index helpers for the sliding line-window generator.
package lwg_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      RD_ROW = 1'b1
   } lwg_state_e;

   // Number of horizontal window positions in one image line.
   function automatic int win_count(input int img_w, input int ksize);
      return img_w - ksize + 1;
   endfunction

   // Ring index arithmetic; modn need not be a power of two.
   function automatic int wrap_add(input int base, input int off, input int modn);
      return (base + off) % modn;
   endfunction

endpackage

// File: rtl/lwg_line_buffer.sv
// One image line of pixel storage: single write port, registered read of KSIZE adjacent pixels.
// Read data updates only when i_re is high, so it holds steady while the consumer stalls.
module lwg_line_buffer #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 512,
   parameter int KSIZE = 3
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_we,
   input  logic [$clog2(IMG_W)-1:0]   i_waddr,
   input  logic [PIX_W-1:0]           i_wdata,
   input  logic                       i_re,
   input  logic [$clog2(IMG_W)-1:0]   i_raddr,
   output logic [KSIZE*PIX_W-1:0]     o_rdata
);

   localparam int AW = $clog2(IMG_W);

   logic [PIX_W-1:0]       mem_q [IMG_W];
   logic [KSIZE*PIX_W-1:0] rdata_d;
   logic [KSIZE*PIX_W-1:0] rdata_q;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   // Columns past the line end read as zero; never reached for legal window positions.
   always_comb begin
      rdata_d = '0;
      for (int k = 0; k < KSIZE; k++) begin
         if (int'(i_raddr) + k < IMG_W) begin
            rdata_d[k*PIX_W +: PIX_W] = mem_q[AW'(int'(i_raddr) + k)];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rdata_q <= '0;
      end else if (i_re) begin
         rdata_q <= rdata_d;
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/line_window_gen.sv
// Raster pixels into KSIZE+1 rotating line buffers; emits KSIZE x KSIZE windows one per cycle.
// First window 1 cycle after a row is ready; windows hold while i_out_ready is low; input stalls when all buffers are full.
module line_window_gen
   import lwg_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int IMG_W = 512,
   parameter int KSIZE = 3
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [PIX_W-1:0]                i_pixel_data,
   input  logic                            i_data_valid,
   output logic                            o_in_ready,
   output logic [KSIZE*KSIZE*PIX_W-1:0]    o_pixel_data,
   output logic                            o_pixel_data_valid,
   input  logic                            i_out_ready,
   output logic                            o_intr
);

   localparam int NUM_LB  = KSIZE + 1;
   localparam int CW      = $clog2(IMG_W);
   localparam int SW      = $clog2(NUM_LB);
   localparam int LW      = $clog2(NUM_LB + 1);
   localparam int WIN_CNT = win_count(IMG_W, KSIZE);

   localparam logic [CW-1:0] COL_MAX    = CW'(IMG_W - 1);
   localparam logic [CW-1:0] WIN_LAST   = CW'(WIN_CNT - 1);
   localparam logic [CW-1:0] WIN_END    = CW'(WIN_CNT);
   localparam logic [SW-1:0] SEL_MAX    = SW'(NUM_LB - 1);
   localparam logic [LW-1:0] LINES_FULL = LW'(NUM_LB);
   localparam logic [LW-1:0] LINES_MIN  = LW'(KSIZE);

   lwg_state_e    state_q, state_d;
   logic [CW-1:0] wr_col_q, wr_col_d;
   logic [SW-1:0] wr_sel_q, wr_sel_d;
   logic [SW-1:0] rd_sel_q, rd_sel_d;
   logic [CW-1:0] rd_col_q, rd_col_d;
   logic [CW-1:0] iss_col_q, iss_col_d;
   logic [LW-1:0] lines_q, lines_d;
   logic          vld_q, vld_d;
   logic          intr_q, intr_d;

   logic          wr_fire;
   logic          wr_line_done;
   logic          out_fire;
   logic          row_done;
   logic          rd_issue;
   logic [SW-1:0] skip_sel;
   logic [SW-1:0] row_sel [KSIZE];

   logic [KSIZE*PIX_W-1:0] lb_rdata [NUM_LB];

   assign o_in_ready         = (lines_q < LINES_FULL);
   assign o_pixel_data_valid = vld_q;
   assign o_intr             = intr_q;

   // Write side: fill the current line, then rotate to the next buffer.
   always_comb begin
      wr_col_d     = wr_col_q;
      wr_sel_d     = wr_sel_q;
      wr_line_done = 1'b0;
      wr_fire      = i_data_valid && o_in_ready;
      if (wr_fire) begin
         if (wr_col_q == COL_MAX) begin
            wr_col_d     = '0;
            wr_line_done = 1'b1;
            wr_sel_d     = (wr_sel_q == SEL_MAX) ? '0 : wr_sel_q + 1'b1;
         end else begin
            wr_col_d = wr_col_q + 1'b1;
         end
      end
   end

   // Read FSM: iss_col runs ahead of rd_col by the one window sitting in the output register.
   always_comb begin
      state_d   = state_q;
      rd_sel_d  = rd_sel_q;
      rd_col_d  = rd_col_q;
      iss_col_d = iss_col_q;
      vld_d     = vld_q;
      intr_d    = 1'b0;
      row_done  = 1'b0;
      rd_issue  = 1'b0;
      out_fire  = vld_q && i_out_ready;
      case (state_q)
         IDLE: begin
            if (lines_q >= LINES_MIN) begin
               state_d   = RD_ROW;
               rd_col_d  = '0;
               iss_col_d = '0;
            end
         end
         RD_ROW: begin
            if (out_fire) begin
               if (rd_col_q == WIN_LAST) begin
                  intr_d   = 1'b1;
                  row_done = 1'b1;
                  rd_sel_d = (rd_sel_q == SEL_MAX) ? '0 : rd_sel_q + 1'b1;
                  state_d  = IDLE;
               end else begin
                  rd_col_d = rd_col_q + 1'b1;
               end
            end
            if (!vld_q || i_out_ready) begin
               if (iss_col_q != WIN_END) begin
                  rd_issue  = 1'b1;
                  vld_d     = 1'b1;
                  iss_col_d = iss_col_q + 1'b1;
               end else begin
                  vld_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case ({wr_line_done, row_done})
         2'b10:   lines_d = lines_q + 1'b1;
         2'b01:   lines_d = lines_q - 1'b1;
         default: lines_d = lines_q;
      endcase
   end

   // Row r of the window lives in buffer rd_sel+r; the buffer after the window is never read.
   always_comb begin
      skip_sel = SW'(wrap_add(int'(rd_sel_q), KSIZE, NUM_LB));
      for (int r = 0; r < KSIZE; r++) begin
         row_sel[r] = SW'(wrap_add(int'(rd_sel_q), r, NUM_LB));
      end
   end

   for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
      logic lb_we;
      logic lb_re;
      assign lb_we = wr_fire && (wr_sel_q == SW'(g));
      assign lb_re = rd_issue && (skip_sel != SW'(g));
      lwg_line_buffer #(
         .PIX_W (PIX_W),
         .IMG_W (IMG_W),
         .KSIZE (KSIZE)
      ) u_lb (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_we    (lb_we),
         .i_waddr (wr_col_q),
         .i_wdata (i_pixel_data),
         .i_re    (lb_re),
         .i_raddr (iss_col_q),
         .o_rdata (lb_rdata[g])
      );
   end

   always_comb begin
      o_pixel_data = '0;
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE; c++) begin
            o_pixel_data[(r*KSIZE+c)*PIX_W +: PIX_W] = lb_rdata[row_sel[r]][c*PIX_W +: PIX_W];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         wr_col_q  <= '0;
         wr_sel_q  <= '0;
         rd_sel_q  <= '0;
         rd_col_q  <= '0;
         iss_col_q <= '0;
         lines_q   <= '0;
         vld_q     <= 1'b0;
         intr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_col_q  <= wr_col_d;
         wr_sel_q  <= wr_sel_d;
         rd_sel_q  <= rd_sel_d;
         rd_col_q  <= rd_col_d;
         iss_col_q <= iss_col_d;
         lines_q   <= lines_d;
         vld_q     <= vld_d;
         intr_q    <= intr_d;
      end
   end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench: a 3x3 / 8-wide instance and a 5x5 / 16-wide instance share stimulus; use5 picks which one is observed.
module tb_line_window_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, dv, ordy, use5, mon_clr;
   logic [7:0]   pix;
   logic         in_rdy3, vld3, intr3, in_rdy5, vld5, intr5;
   logic [71:0]  dat3;
   logic [199:0] dat5;

   logic         sel_in_rdy, sel_vld, sel_intr;
   logic [199:0] sel_dat;
   int           sel_w;

   int checks = 0;
   int failures = 0;

   line_window_gen #(.PIX_W(8), .IMG_W(8), .KSIZE(3)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_data_valid(dv),
      .o_in_ready(in_rdy3), .o_pixel_data(dat3), .o_pixel_data_valid(vld3),
      .i_out_ready(ordy), .o_intr(intr3)
   );

   line_window_gen #(.PIX_W(8), .IMG_W(16), .KSIZE(5)) dut5 (
      .i_clk(clk), .i_rst(rst), .i_pixel_data(pix), .i_data_valid(dv),
      .o_in_ready(in_rdy5), .o_pixel_data(dat5), .o_pixel_data_valid(vld5),
      .i_out_ready(ordy), .o_intr(intr5)
   );

   assign sel_in_rdy = use5 ? in_rdy5 : in_rdy3;
   assign sel_vld    = use5 ? vld5 : vld3;
   assign sel_intr   = use5 ? intr5 : intr3;
   assign sel_dat    = use5 ? dat5 : {128'd0, dat3};
   assign sel_w      = use5 ? 16 : 8;

   // Observation log filled on the falling edge, where handshakes are stable.
   logic [199:0] win_q [$];
   int           win_cyc [$];
   int           cyc = 0;
   int           intr_cnt, intr_first_cyc, intr_first_wins, acc_pix, pix32_cyc, stall_viol, max_stored;
   logic [199:0] prev_dat;
   logic         prev_stall;
   int           drv_timeout;

   always @(negedge clk) begin
      cyc++;
      if (mon_clr) begin
         win_q.delete();
         win_cyc.delete();
         intr_cnt = 0; intr_first_cyc = -1; intr_first_wins = -1;
         acc_pix = 0; pix32_cyc = -1; stall_viol = 0; max_stored = 0;
         prev_stall = 1'b0; prev_dat = '0;
      end else begin
         if (prev_stall && sel_vld && (sel_dat !== prev_dat)) stall_viol++;
         prev_stall = sel_vld && !ordy;
         prev_dat   = sel_dat;
         if (sel_intr) begin
            if (intr_cnt == 0) begin
               intr_first_cyc  = cyc;
               intr_first_wins = win_q.size();
            end
            intr_cnt++;
         end
         if (sel_vld && ordy) begin
            win_q.push_back(sel_dat);
            win_cyc.push_back(cyc);
         end
         if (dv && sel_in_rdy) begin
            if (acc_pix == 32) pix32_cyc = cyc;
            acc_pix++;
         end
         if (acc_pix / sel_w - intr_cnt > max_stored) max_stored = acc_pix / sel_w - intr_cnt;
      end
   end

   function automatic logic [199:0] exp_win(input int k, input int j, input int ks);
      logic [199:0] w;
      w = '0;
      for (int r = 0; r < ks; r++)
         for (int c = 0; c < ks; c++)
            w[(r*ks+c)*8 +: 8] = 8'((k + r) * 16 + j + c);
      return w;
   endfunction

   function automatic logic [199:0] win_at(input int idx);
      if (idx < win_q.size()) return win_q[idx];
      return 'x;
   endfunction

   task automatic send_lines(input int first, input int n, input int w);
      for (int l = 0; l < n; l++) begin
         for (int j = 0; j < w; j++) begin
            bit ok;
            int t;
            pix = 8'((first + l) * 16 + j);
            dv  = 1'b1;
            ok  = 1'b0;
            t   = 0;
            while (!ok && t < 3000) begin
               @(negedge clk);
               ok = sel_in_rdy;
               @(posedge clk);
               #1;
               t++;
            end
            if (!ok) begin
               drv_timeout++;
               dv = 1'b0;
               return;
            end
         end
      end
      dv = 1'b0;
   endtask

   task automatic wait_wins(input int n, input int budget);
      for (int t = 0; t < budget && win_q.size() < n; t++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; dv = 1'b0; ordy = 1'b0; drv_timeout = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_clr = 1'b1;
      @(posedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic test_reset();
      use5 = 1'b0;
      do_reset();
      checks++; if (vld3 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", vld3); end
      checks++; if (intr3 !== 1'b0) begin failures++; $display("FAIL reset_intr got=%b exp=0", intr3); end
      checks++; if (dat3 !== 72'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", dat3); end
      checks++; if (in_rdy3 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_rdy3); end
      checks++; if (vld5 !== 1'b0 || dat5 !== 200'd0) begin failures++; $display("FAIL reset_k5 got=%b/%h exp=0/0", vld5, dat5); end
   endtask

   task automatic test_basic();
      use5 = 1'b0;
      do_reset();
      ordy = 1'b1;
      send_lines(0, 3, 8);
      wait_wins(6, 300);
      settle(20);
      checks++; if (win_q.size() != 6) begin failures++; $display("FAIL basic_count got=%0d exp=6", win_q.size()); end
      checks++; if (win_at(0) !== 200'h22_21_20_12_11_10_02_01_00) begin failures++; $display("FAIL basic_first got=%h exp=222120121110020100", win_at(0)); end
      for (int j = 0; j < 6; j++) begin
         checks++;
         if (win_at(j) !== exp_win(0, j, 3)) begin failures++; $display("FAIL basic_win%0d got=%h exp=%h", j, win_at(j), exp_win(0, j, 3)); end
      end
      checks++; if (intr_cnt != 1) begin failures++; $display("FAIL basic_intr_cnt got=%0d exp=1", intr_cnt); end
      checks++; if (intr_first_wins != 6) begin failures++; $display("FAIL basic_intr_pos got=%0d exp=6", intr_first_wins); end
      checks++;
      if (win_cyc.size() < 6 || win_cyc[5] - win_cyc[0] != 5) begin
         failures++; $display("FAIL basic_b2b got=%0d exp=5", (win_cyc.size() < 6) ? -1 : win_cyc[5] - win_cyc[0]);
      end
      checks++; if (drv_timeout != 0) begin failures++; $display("FAIL basic_drv_timeout got=%0d exp=0", drv_timeout); end
   endtask

   task automatic test_stall();
      logic [3:0] pat;
      pat = 4'b1001;
      use5 = 1'b0;
      do_reset();
      fork
         send_lines(0, 3, 8);
         for (int t = 0; t < 400 && win_q.size() < 6; t++) begin
            ordy = pat[t % 4];
            @(posedge clk);
            #1;
         end
      join
      ordy = 1'b1;
      settle(20);
      checks++; if (win_q.size() != 6) begin failures++; $display("FAIL stall_count got=%0d exp=6", win_q.size()); end
      for (int j = 0; j < 6; j++) begin
         checks++;
         if (win_at(j) !== exp_win(0, j, 3)) begin failures++; $display("FAIL stall_win%0d got=%h exp=%h", j, win_at(j), exp_win(0, j, 3)); end
      end
      checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stall_viol); end
      checks++; if (intr_cnt != 1) begin failures++; $display("FAIL stall_intr got=%0d exp=1", intr_cnt); end
   endtask

   task automatic test_backpressure();
      use5 = 1'b0;
      do_reset();
      ordy = 1'b0;
      fork
         send_lines(0, 6, 8);
         begin
            settle(60);
            checks++; if (in_rdy3 !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_rdy3); end
            checks++; if (acc_pix != 32) begin failures++; $display("FAIL bp_accepted got=%0d exp=32", acc_pix); end
            ordy = 1'b1;
         end
      join
      wait_wins(24, 400);
      settle(20);
      checks++; if (win_q.size() != 24) begin failures++; $display("FAIL bp_count got=%0d exp=24", win_q.size()); end
      checks++; if (intr_cnt != 4) begin failures++; $display("FAIL bp_intr got=%0d exp=4", intr_cnt); end
      checks++;
      if (pix32_cyc < 0 || pix32_cyc < intr_first_cyc) begin
         failures++; $display("FAIL bp_pix32_order got=%0d exp>=%0d", pix32_cyc, intr_first_cyc);
      end
      checks++; if (win_at(18) !== exp_win(3, 0, 3)) begin failures++; $display("FAIL bp_row3 got=%h exp=%h", win_at(18), exp_win(3, 0, 3)); end
      checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_viol); end
   endtask

   task automatic test_continuous();
      logic [199:0] w;
      use5 = 1'b0;
      do_reset();
      ordy = 1'b1;
      send_lines(0, 10, 8);
      wait_wins(48, 600);
      settle(20);
      checks++; if (intr_cnt != 8) begin failures++; $display("FAIL cont_intr got=%0d exp=8", intr_cnt); end
      checks++; if (win_q.size() != 48) begin failures++; $display("FAIL cont_count got=%0d exp=48", win_q.size()); end
      checks++; if (max_stored > 4) begin failures++; $display("FAIL cont_lines_stored got=%0d exp<=4", max_stored); end
      for (int k = 0; k < 8; k++) begin
         w = win_at(k * 6);
         checks++;
         if (w[7:0] !== 8'(k * 16)) begin failures++; $display("FAIL cont_row%0d got=%h exp=%h", k, w[7:0], 8'(k * 16)); end
      end
      checks++; if (drv_timeout != 0) begin failures++; $display("FAIL cont_drv_timeout got=%0d exp=0", drv_timeout); end
   endtask

   task automatic test_reset_mid();
      use5 = 1'b0;
      do_reset();
      ordy = 1'b1;
      send_lines(0, 3, 8);
      wait_wins(3, 300);
      rst  = 1'b1;
      ordy = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (vld3 !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", vld3); end
      checks++; if (intr3 !== 1'b0) begin failures++; $display("FAIL rmid_intr got=%b exp=0", intr3); end
      checks++; if (dat3 !== 72'd0) begin failures++; $display("FAIL rmid_data got=%h exp=0", dat3); end
      checks++; if (in_rdy3 !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_rdy3); end
      mon_clr = 1'b1;
      @(posedge clk);
      #1;
      mon_clr = 1'b0;
      ordy = 1'b1;
      send_lines(0, 3, 8);
      wait_wins(6, 300);
      settle(30);
      checks++; if (win_q.size() != 6) begin failures++; $display("FAIL rmid_count got=%0d exp=6", win_q.size()); end
      checks++; if (win_at(0) !== 200'h22_21_20_12_11_10_02_01_00) begin failures++; $display("FAIL rmid_first got=%h exp=222120121110020100", win_at(0)); end
      checks++; if (win_at(5) !== exp_win(0, 5, 3)) begin failures++; $display("FAIL rmid_last got=%h exp=%h", win_at(5), exp_win(0, 5, 3)); end
      checks++; if (intr_cnt != 1) begin failures++; $display("FAIL rmid_intr_cnt got=%0d exp=1", intr_cnt); end
   endtask

   task automatic test_k5();
      logic [199:0] w;
      use5 = 1'b1;
      do_reset();
      ordy = 1'b1;
      send_lines(0, 5, 16);
      wait_wins(12, 400);
      settle(20);
      checks++; if (win_q.size() != 12) begin failures++; $display("FAIL k5_count got=%0d exp=12", win_q.size()); end
      checks++; if (intr_cnt != 1) begin failures++; $display("FAIL k5_intr got=%0d exp=1", intr_cnt); end
      for (int j = 0; j < 12; j++) begin
         checks++;
         if (win_at(j) !== exp_win(0, j, 5)) begin failures++; $display("FAIL k5_win%0d got=%h exp=%h", j, win_at(j), exp_win(0, j, 5)); end
      end
      w = win_at(11);
      checks++; if (w[199:192] !== 8'h4F) begin failures++; $display("FAIL k5_elem44 got=%h exp=4f", w[199:192]); end
   endtask

   initial begin
      rst = 1'b1; dv = 1'b0; ordy = 1'b0; pix = '0; use5 = 1'b0; mon_clr = 1'b1; drv_timeout = 0;
      test_reset();
      test_basic();
      test_stall();
      test_backpressure();
      test_continuous();
      test_reset_mid();
      test_k5();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
